// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the down_counter block and its terminal-count detector.
package down_counter_pkg;

  localparam int unsigned DC_WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dc_state_e;

endpackage

// File: rtl/down_counter_tc.sv
// Registered terminal-count detector: emits a one-cycle pulse on the edge where the
// tracked count first becomes 0 (or hits its expiry step) and clears otherwise.
module down_counter_tc
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] count_next,
  output logic             tc
);

  logic tc_d;

  // A load decides on its own value; otherwise only the 1->0 decrement step expires,
  // which also covers auto-reload where count_next is not 0.
  always_comb begin
    tc_d = 1'b0;
    if (load) begin
      tc_d = (count_next == '0);
    end else if (step) begin
      tc_d = (count == WIDTH'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc <= 1'b0;
    end else begin
      tc <= tc_d;
    end
  end

endmodule

// File: rtl/down_counter.sv
// Loadable, enable-gated down-counter with registered terminal-count pulse.
// Optional auto-reload on expiry when DOWN_COUNTER_AUTORELOAD_EN is defined.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  dc_state_e        state;
  dc_state_e        state_next;
  logic [WIDTH-1:0] count_next;
  logic             step;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= load_val;
    end
  end
`endif

  assign step = (state == RUN) && en && !load;

  always_comb begin
    state_next = state;
    count_next = count;
    if (load) begin
      count_next = load_val;
      state_next = (load_val != '0) ? RUN : IDLE;
    end else if (step) begin
      if (count > WIDTH'(1)) begin
        count_next = count - WIDTH'(1);
      end else if (count == WIDTH'(1)) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        count_next = reload_q;
        state_next = RUN;
`else
        count_next = '0;
        state_next = IDLE;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  assign busy = (state == RUN);

  down_counter_tc #(
    .WIDTH(WIDTH)
  ) u_tc (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .count      (count),
    .count_next (count_next),
    .tc         (tc)
  );

endmodule

// File: doc/down_counter.md
# down_counter

Synchronous, loadable, enable-gated down-counter with a single-cycle terminal-count pulse. It is the counting-down counterpart to the team's ripple up-counter. It serves as the interval timer and countdown source for blocks that load a period and wait for expiry. All state is held in registers on one clock, so there are no ripple delays between bits.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- load  input  1  load `load_val` on the next edge; has priority over `en`
- load_val  input  WIDTH  start value
- en  input  1  decrement enable, sampled while in RUN
- count  output  WIDTH  current registered count
- tc  output  1  terminal-count pulse, registered, one cycle wide
- busy  output  1  high while in RUN

## Operation
- FSM states: IDLE, RUN.
- Reset (async, any time, including mid-count): state IDLE, `count`=0, `tc`=0, `busy`=0, reload register=0.
- IDLE:
  - `count` holds; `en` is ignored, so there is no wrap to all-ones.
  - `load` with `load_val`≠0 → RUN, `count`=`load_val`.
  - `load` with `load_val`=0 → stay IDLE, `count`=0, `tc`=1 for one cycle.
- RUN:
  - `en`=1 and `count`>1 → `count`−1.
  - `en`=1 and `count`=1 → `count` reaches 0 and `tc`=1 for one cycle; the next state depends on the Configuration macro.
  - `en`=0 → `count` and state hold (pause); `tc`=0.
- `load` in RUN restarts the count: `count`=`load_val` and any pending decrement that cycle is discarded. `load_val`=0 follows the IDLE rule above.
- Arithmetic is unsigned modulo 2^WIDTH. Decrement only happens from `count`≥1, so underflow is impossible.
- `busy` = (state==RUN), registered with the state.

## Timing
- `count`, `tc` and `busy` all change only on a rising `clk` edge or on `rst`.
- Load latency is 1 cycle: `load_val` appears on `count` after the edge that samples `load`=1.
- Countdown length: a load of N with `en` held high gives N decrement edges. `tc` is high during the cycle in which `count` first shows 0, with no extra cycle of delay.
- `tc` is never high for two consecutive cycles, except when consecutive loads of 0 are made or when auto-reload is configured with N=1.
- Simultaneous `load` and `en`: `load` wins.
- Simultaneous `load` on the same edge as a 1→0 transition: `load` wins and no `tc` is issued.
- `rst` asserted mid-count: all outputs clear immediately (async). The first load after deassertion starts cleanly.

## Configuration
- Macro: `DOWN_COUNTER_AUTORELOAD_EN`.
- Defined:
  - A WIDTH-bit reload register captures `load_val` on every `load`.
  - On the 1→0 step in RUN, `count` takes the reload value instead of 0, `tc`=1, and the state stays RUN.
  - `count` never shows 0 while auto-reloading, so the period is exactly N cycles with `en` held high.
  - Leaving RUN requires `rst` or a load of 0.
- Undefined:
  - The reload register is not instantiated.
  - On the 1→0 step, `count`=0, `tc`=1 and the state goes to IDLE, so `busy` falls on the same edge.

## Structure
- Package `down_counter_pkg`:
  - state enum typedef (IDLE, RUN)
  - default-width constant `DC_WIDTH_DEFAULT`=4
- Sub-module `down_counter_tc`: a registered terminal-count detector. It takes next-count/current-count and load, and produces the one-cycle `tc`. It is reused wherever the team needs an expiry pulse.
- Top level holds the FSM, the count register and the optional reload register.

## Test plan
- Reset and idle: assert `rst` mid-cycle → `count`=0, `tc`=0, `busy`=0 with no clock edge. Then `en`=1 in IDLE for 5 cycles → `count` stays 0 (no wrap to 4'b1111).
- Basic countdown: load 5 with `en`=1 → `count` goes 5,4,3,2,1,0; `tc`=1 only in the cycle showing 0. Without the macro, `busy` falls on that same edge.
- Pause and priority: load 9, decrement twice, drop `en` for 3 cycles → `count` holds at 7. Then `load`=1 with `load_val`=3 while `en`=1 → `count`=3, not 6.
- Zero and boundary loads: load 0 → `tc` pulses once and the state stays IDLE. Load 15 (WIDTH=4) → exactly 15 decrements before `tc`.
- Auto-reload (macro defined): load 3 with `en` held high → `count` runs 3,2,1,3,2,1…; `tc` pulses every 3rd cycle; `busy` stays 1.
- Reset mid-operation: load 12, decrement to 8, pulse `rst` → `count`=0 immediately. Then load 2 → normal 2,1,0 with one `tc`.
